// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encodings and FSM states.
package onehot_scan_pkg;

    // Encoding of the mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Top-level operating state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control and result bundle of the one-hot scan decoder.
// The master drives the controls; the slave (the decoder) drives the results.
interface onehot_scan_decoder_if #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 2 ** SEL_W,
    parameter int unsigned DWELL_W = 8
);

    // Controls
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   din;
    logic [DWELL_W-1:0] dwell;

    // Registered results
    logic [NUM_OUT-1:0] dout;
    logic [SEL_W-1:0]   idx;
    logic               valid;
    logic               wrap;
    logic               err;

    modport master (
        output en,
        output mode,
        output din,
        output dwell,
        input  dout,
        input  idx,
        input  valid,
        input  wrap,
        input  err
    );

    modport slave (
        input  en,
        input  mode,
        input  din,
        input  dwell,
        output dout,
        output idx,
        output valid,
        output wrap,
        output err
    );

endinterface

// File: rtl/onehot_scan_decoder_scan_tick_gen.sv
// Dwell down-counter for the scan walker. Emits a one-cycle advance tick when
// the count reads zero while running, and reloads from the live dwell value then.
module scan_tick_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,   // scan entry: load dwell, no tick
    input  logic               run,       // scan in progress
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] count_q;

    // The tick is qualified by run so a stale zero never advances on entry.
    assign tick = run && (count_q == '0);

    // Dwell counter: load on entry, count down while running, reload on expiry.
    // A dwell change is only sampled at a load, never applied to a running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= dwell;
        end else if (run) begin
            if (count_q == '0) begin
                count_q <= dwell;
            end else begin
                count_q <= count_q - DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a direct-decode mode and an autonomous scan
// mode that walks a single active line across NUM_OUT outputs.
module onehot_scan_decoder
    import onehot_scan_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 2 ** SEL_W,
    parameter int unsigned DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    onehot_scan_decoder_if.slave bus
);

    // Comparison constants sized to the select width.
    localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_OUT - 1);

    state_e             state_q;
    logic [NUM_OUT-1:0] dout_q;
    logic [SEL_W-1:0]   idx_q;
    logic               valid_q;
    logic               wrap_q;
    logic               err_q;

    logic               scan_sel;
    logic               scan_entry;
    logic               scan_run;
    logic               tick;
    logic               din_ok;
    logic               last_idx;
    logic [SEL_W-1:0]   idx_next;
    logic [NUM_OUT-1:0] din_onehot;
    logic [NUM_OUT-1:0] next_onehot;

    // Entry covers IDLE->SCAN and DIRECT->SCAN, including the first edge after reset.
    assign scan_sel   = bus.en && (bus.mode == MODE_SCAN);
    assign scan_entry = scan_sel && (state_q != SCAN);
    assign scan_run   = scan_sel && (state_q == SCAN);

    scan_tick_gen #(
        .DWELL_W (DWELL_W)
    ) u_scan_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (scan_entry),
        .run     (scan_run),
        .dwell   (bus.dwell),
        .tick    (tick)
    );

    // Range check of the direct select; NUM_OUT may be below 2**SEL_W.
    assign din_ok = ({1'b0, bus.din} < NUM_OUT_EXT);

    // Next scan position, wrapping at the last implemented output.
    always_comb begin
        last_idx = (idx_q == LAST_IDX);
        idx_next = last_idx ? '0 : idx_q + SEL_W'(1);
    end

    // One-hot decode of the direct select and of the next scan position.
    always_comb begin
        din_onehot  = '0;
        next_onehot = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            din_onehot[i]  = (bus.din == SEL_W'(i));
            next_onehot[i] = (idx_next == SEL_W'(i));
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (!bus.en) begin
            // idx is deliberately left holding its last value.
            state_q <= IDLE;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.mode == MODE_DIRECT) begin
            state_q <= DIRECT;
            wrap_q  <= 1'b0;
            if (din_ok) begin
                dout_q  <= din_onehot;
                idx_q   <= bus.din;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
            end else begin
                dout_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b1;
            end
        end else begin
            state_q <= SCAN;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            if (state_q != SCAN) begin
                idx_q  <= '0;
                dout_q <= NUM_OUT'(1);
                wrap_q <= 1'b0;
            end else if (tick) begin
                idx_q  <= idx_next;
                dout_q <= next_onehot;
                wrap_q <= last_idx;
            end else begin
                wrap_q <= 1'b0;
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered successor to the 2-to-4 combinational decoder. It produces a one-hot select vector of `NUM_OUT` lines in one of two modes:

- **Direct decode** of a binary input.
- **Autonomous scan**, which walks a single active line through outputs 0..`NUM_OUT`-1 with a programmable dwell time.

It sits in front of multiplexed display digits, row selects and chip-select fans, where a static decoder or a free-running walker is needed.

## Interface
Parameters:
- `SEL_W`, default 2: width of the binary select and index.
- `NUM_OUT`, default `2**SEL_W`: number of one-hot outputs. Legal range is 2..`2**SEL_W`.
- `DWELL_W`, default 8: width of the dwell-count input.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: block enable.
- `mode`, input, 1: 0 = DIRECT, 1 = SCAN.
- `din`, input, `SEL_W`: binary select, used in DIRECT mode.
- `dwell`, input, `DWELL_W`: each scan position is held for `dwell+1` cycles.
- `dout`, output, `NUM_OUT`: registered one-hot select.
- `idx`, output, `SEL_W`: binary index of the active line.
- `valid`, output, 1: `dout` holds exactly one active bit.
- `wrap`, output, 1: one-cycle pulse when the scan returns from `NUM_OUT`-1 to 0.
- `err`, output, 1: registered flag, DIRECT mode, `din` >= `NUM_OUT`.

## Operation
Reset (asynchronous, immediate):
- `dout`=0, `idx`=0, `valid`=0, `wrap`=0, `err`=0.
- Internal dwell counter = 0.
- Internal state = IDLE.

States and transitions (evaluated each clock):
- **IDLE**: entered whenever `en`=0.
  - Outputs `dout`=0, `valid`=0, `wrap`=0, `err`=0.
  - `idx` holds its last value.
  - Exits to DIRECT or SCAN according to `mode` when `en`=1.
- **DIRECT** (`en`=1, `mode`=0):
  - If `din` < `NUM_OUT`: `dout` <= 1<<`din`, `idx` <= `din`, `valid` <= 1, `err` <= 0.
  - Otherwise: `dout` <= 0, `valid` <= 0, `err` <= 1, `idx` holds.
  - `wrap` = 0.
- **SCAN** (`en`=1, `mode`=1):
  - On entry from IDLE or DIRECT: `idx` <= 0, `dout` <= 1, dwell counter <= `dwell`, `valid` <= 1.
  - While in SCAN, the dwell counter decrements each cycle. When it reads 0:
    - `idx` advances; `idx` = `NUM_OUT`-1 wraps to 0 and pulses `wrap` for exactly that cycle.
    - `dout` <= 1<<(new `idx`).
    - The counter reloads from the current `dwell`.
  - `err` = 0 throughout.

Boundary rules:
- `dwell`=0 advances every cycle.
- A `dwell` change takes effect at the next reload only; the current count is never modified.
- `NUM_OUT` < `2**SEL_W`: scan never visits indices >= `NUM_OUT`.
- `mode` change while `en`=1 is treated as entry to the new state on the next edge; the dwell count is discarded.
- `en` deasserted mid-scan goes to IDLE; re-enabling SCAN restarts at `idx` 0.
- `rst` asserted mid-operation: outputs clear immediately; the first post-reset edge with `en`=1 is treated as a state entry.

## Timing
- DIRECT latency: 1 cycle from `din` sample to `dout`, `idx` and `err`.
- SCAN: the first active line appears 1 cycle after entry. Each position is held for `dwell+1` cycles, so a full scan period is `NUM_OUT*(dwell+1)` cycles.
- `wrap` is asserted in the same cycle `dout` shows bit 0 after bit `NUM_OUT`-1.
- All outputs are registered; there is no combinational path from input to output.
- `dout` is always zero or one-hot, never multi-hot, including on every transition cycle.

## Structure
- Shared package: `onehot_scan_pkg` holds
  - the mode encodings `MODE_DIRECT`=1'b0 and `MODE_SCAN`=1'b1;
  - the state enum IDLE/DIRECT/SCAN.
- One natural sub-module, `scan_tick_gen`:
  - contains the dwell down-counter, with reload and restart inputs;
  - emits a single-cycle advance `tick`.
- The top level holds the state register, index register, decode and flags.

## Test plan
- **DIRECT sweep.** Defaults, `en`=1, `mode`=0, `din` 0,1,2,3 for 10 cycles each -> `dout` 0001, 0010, 0100, 1000 one cycle after each change; `valid`=1; `err`=0.
- **Out-of-range input.** `NUM_OUT`=3, `din`=3 -> next cycle `dout`=000, `valid`=0, `err`=1. Then `din`=1 -> `dout`=010, `err`=0.
- **SCAN with dwell 2.** `mode`=1, `dwell`=2 -> `idx` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. `wrap` is high only on the cycle `idx` returns to 0, i.e. 12 cycles after the first active cycle.
- **SCAN with dwell 0 and mid-scan disable.** `dwell`=0, one-hot walks every cycle. Drop `en` at `idx`=2 -> `dout`=0 next cycle. Re-enable -> restarts at `idx` 0.
- **Asynchronous reset mid-scan.** Assert `rst` between clock edges during SCAN -> all outputs 0 immediately, with no clock needed. Release -> SCAN restarts at `idx` 0 with a full dwell.
- **Dwell and mode change mid-operation.** Change `dwell` from 5 to 1 mid-position -> the current position still lasts 6 cycles, subsequent positions 2. Switch `mode` to DIRECT with `din`=1 -> `dout`=0010 after 1 cycle.
